// File: rtl/alu_seq_n_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_n_if
// Description : Request/response bundle for the sequential ALU.
//               master : drives start, Operand1, Operand2, Opcode;
//                        observes busy, done, Result, flagC, flagZ.
//               slave  : the ALU side of the same bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_seq_n_if #(
    parameter int WIDTH = 32
);
    logic                 start;
    logic [WIDTH-1:0]     Operand1;
    logic [WIDTH-1:0]     Operand2;
    logic [3:0]           Opcode;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   Result;
    logic                 flagC;
    logic                 flagZ;

    modport master (
        output start, Operand1, Operand2, Opcode,
        input  busy, done, Result, flagC, flagZ
    );

    modport slave (
        input  start, Operand1, Operand2, Opcode,
        output busy, done, Result, flagC, flagZ
    );
endinterface
`default_nettype wire

// File: rtl/alu_seq_n.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_n
// Description : Sequential ALU. Single-cycle logic/arithmetic/shift ops,
//               shift-add multiply and restoring divide at one bit per cycle.
// Ports       : clk  - clock, all state on the rising edge
//               rst  - synchronous active-high reset
//               bus  - alu_seq_n_if.slave: start/Operand1/Operand2/Opcode in,
//                      busy/done/Result/flagC/flagZ out
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_n #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    alu_seq_n_if.slave bus
);
    localparam int               SH         = $clog2(WIDTH);
    localparam logic [SH:0]      c_WIDTH_V  = (SH+1)'(WIDTH);
    localparam logic [WIDTH-1:0] c_ONE      = WIDTH'(1);
    localparam logic [SH-1:0]    c_CNT_ONE  = SH'(1);
    localparam logic [SH-1:0]    c_CNT_LAST = '1;
    localparam logic [3:0]       c_OP_MUL   = 4'd14;
    localparam logic [3:0]       c_OP_DIV   = 4'd15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MUL  = 2'd2,
        DIV  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     op_a_q, op_a_d;
    logic [WIDTH-1:0]     op_b_q, op_b_d;
    logic [3:0]           opcode_q, opcode_d;
    // hi/lo: MUL -> {partial product, remaining multiplier bits}
    //        DIV -> {partial remainder, dividend shifting into quotient}
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic [SH-1:0]        cnt_q, cnt_d;
    logic                 done_q, done_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 flag_c_q, flag_c_d;
    logic                 flag_z_q, flag_z_d;

    // ------------------------------------------------------------------
    // Single-cycle datapath
    // ------------------------------------------------------------------
    logic [SH-1:0]        w_shamt;
    logic [SH:0]          w_shamt_inv;
    logic [WIDTH:0]       w_add_full, w_sub_full, w_shl_full, w_shr_full;
    logic [WIDTH-1:0]     w_rol, w_ror, w_exec_lo;
    logic                 w_exec_c;
    logic [2*WIDTH-1:0]   w_exec_res;

    always_comb begin
        w_shamt     = op_b_q[SH-1:0];
        // W - s; a shift by the full width yields zero, so s=0 rotates cleanly
        w_shamt_inv = c_WIDTH_V - {1'b0, w_shamt};
        w_add_full  = {1'b0, op_a_q} + {1'b0, op_b_q};
        // top bit of the widened difference is the borrow (A < B)
        w_sub_full  = {1'b0, op_a_q} - {1'b0, op_b_q};
        // extra bit above / below catches the last bit shifted out
        w_shl_full  = {1'b0, op_a_q} << w_shamt;
        w_shr_full  = {op_a_q, 1'b0} >> w_shamt;
        w_rol       = (op_a_q << w_shamt) | (op_a_q >> w_shamt_inv);
        w_ror       = (op_a_q >> w_shamt) | (op_a_q << w_shamt_inv);

        w_exec_lo = '0;
        w_exec_c  = 1'b0;
        case (opcode_q)
            4'd0:  begin w_exec_lo = w_add_full[WIDTH-1:0]; w_exec_c = w_add_full[WIDTH]; end
            4'd1:  begin w_exec_lo = w_sub_full[WIDTH-1:0]; w_exec_c = w_sub_full[WIDTH]; end
            4'd2:  w_exec_lo = op_a_q & op_b_q;
            4'd3:  w_exec_lo = op_a_q | op_b_q;
            4'd4:  w_exec_lo = op_a_q ^ op_b_q;
            4'd5:  w_exec_lo = ~(op_a_q | op_b_q);
            4'd6:  w_exec_lo = ~(op_a_q ^ op_b_q);
            4'd7:  w_exec_lo = ~op_a_q;
            4'd8:  begin w_exec_lo = w_shl_full[WIDTH-1:0]; w_exec_c = w_shl_full[WIDTH]; end
            4'd9:  begin w_exec_lo = w_shr_full[WIDTH:1];   w_exec_c = w_shr_full[0]; end
            4'd10: w_exec_lo = w_rol;
            4'd11: w_exec_lo = w_ror;
            4'd12: begin w_exec_lo = op_a_q + c_ONE; w_exec_c = &op_a_q; end
            4'd13: begin w_exec_lo = op_a_q - c_ONE; w_exec_c = ~|op_a_q; end
            // Divide only reaches this path with a zero divisor
            4'd15: begin w_exec_lo = '1; w_exec_c = 1'b1; end
            default: ;
        endcase
        w_exec_res = {(opcode_q == c_OP_DIV) ? op_a_q : {WIDTH{1'b0}}, w_exec_lo};
    end

    // ------------------------------------------------------------------
    // Iterative step logic
    // ------------------------------------------------------------------
    logic [WIDTH:0]       w_mul_sum;
    logic [WIDTH-1:0]     w_mul_hi, w_mul_lo;
    logic [WIDTH:0]       w_div_shift, w_div_diff;
    logic                 w_div_fit;
    logic [WIDTH-1:0]     w_div_hi, w_div_lo;

    always_comb begin
        // shift-add: add multiplicand when the current multiplier LSB is set,
        // then shift the {carry, hi, lo} chain right by one
        w_mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, op_a_q} : {(WIDTH+1){1'b0}});
        w_mul_hi    = w_mul_sum[WIDTH:1];
        w_mul_lo    = {w_mul_sum[0], lo_q[WIDTH-1:1]};
        // restoring divide: bring down next dividend bit, subtract if it fits
        w_div_shift = {hi_q, lo_q[WIDTH-1]};
        w_div_diff  = w_div_shift - {1'b0, op_b_q};
        w_div_fit   = (w_div_shift >= {1'b0, op_b_q});
        w_div_hi    = w_div_fit ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
        w_div_lo    = {lo_q[WIDTH-2:0], w_div_fit};
    end

    // ------------------------------------------------------------------
    // FSM next-state and output logic
    // ------------------------------------------------------------------
    logic                 w_fin;
    logic [2*WIDTH-1:0]   w_fin_res;
    logic                 w_fin_c;

    always_comb begin
        state_d   = state_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        opcode_d  = opcode_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        result_d  = result_q;
        flag_c_d  = flag_c_q;
        flag_z_d  = flag_z_q;
        w_fin     = 1'b0;
        w_fin_res = '0;
        w_fin_c   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    op_a_d   = bus.Operand1;
                    op_b_d   = bus.Operand2;
                    opcode_d = bus.Opcode;
                    hi_d     = '0;
                    cnt_d    = '0;
                    if (bus.Opcode == c_OP_MUL) begin
                        lo_d    = bus.Operand2;
                        state_d = MUL;
                    end else if (bus.Opcode == c_OP_DIV && bus.Operand2 != '0) begin
                        lo_d    = bus.Operand1;
                        state_d = DIV;
                    end else begin
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                w_fin     = 1'b1;
                w_fin_res = w_exec_res;
                w_fin_c   = w_exec_c;
            end
            MUL: begin
                hi_d  = w_mul_hi;
                lo_d  = w_mul_lo;
                cnt_d = cnt_q + c_CNT_ONE;
                if (cnt_q == c_CNT_LAST) begin
                    w_fin     = 1'b1;
                    w_fin_res = {w_mul_hi, w_mul_lo};
                    w_fin_c   = |w_mul_hi;
                end
            end
            DIV: begin
                hi_d  = w_div_hi;
                lo_d  = w_div_lo;
                cnt_d = cnt_q + c_CNT_ONE;
                if (cnt_q == c_CNT_LAST) begin
                    w_fin     = 1'b1;
                    w_fin_res = {w_div_hi, w_div_lo};
                end
            end
            default: state_d = IDLE;
        endcase

        if (w_fin) begin
            state_d  = IDLE;
            done_d   = 1'b1;
            result_d = w_fin_res;
            flag_c_d = w_fin_c;
            flag_z_d = ~|w_fin_res;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_a_q   <= '0;
            op_b_q   <= '0;
            opcode_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
            flag_c_q <= 1'b0;
            flag_z_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            opcode_q <= opcode_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            result_q <= result_d;
            flag_c_q <= flag_c_d;
            flag_z_q <= flag_z_d;
        end
    end

    assign bus.busy   = (state_q != IDLE);
    assign bus.done   = done_q;
    assign bus.Result = result_q;
    assign bus.flagC  = flag_c_q;
    assign bus.flagZ  = flag_z_q;
endmodule
`default_nettype wire

// File: tb/tb_alu_seq_n.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq_n
// Description : Self-checking bench for alu_seq_n (WIDTH=32). A transaction
//               level model predicts busy/done/Result/flags every cycle;
//               directed vectors pin known results and latencies.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq_n;
    localparam int W = 32;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   acc_cyc  = 0;
    bit   check_en = 1'b0;

    alu_seq_n_if #(.WIDTH(W)) bus ();

    alu_seq_n #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL global_timeout cycles=%0d", cyc);
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference arithmetic: returns {flagC, Result}
    // ------------------------------------------------------------------
    function automatic logic [64:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [4:0]  s;
        logic [32:0] t;
        logic [63:0] d;
        logic [63:0] r;
        logic        c;
        s = b[4:0];
        r = 64'd0;
        c = 1'b0;
        case (op)
            4'd0:  begin t = {1'b0, a} + {1'b0, b}; r[31:0] = t[31:0]; c = t[32]; end
            4'd1:  begin r[31:0] = a - b; c = (a < b); end
            4'd2:  r[31:0] = a & b;
            4'd3:  r[31:0] = a | b;
            4'd4:  r[31:0] = a ^ b;
            4'd5:  r[31:0] = ~(a | b);
            4'd6:  r[31:0] = ~(a ^ b);
            4'd7:  r[31:0] = ~a;
            4'd8:  begin r[31:0] = a << s; if (s != 5'd0) c = a[32 - int'(s)]; end
            4'd9:  begin r[31:0] = a >> s; if (s != 5'd0) c = a[int'(s) - 1]; end
            4'd10: begin d = {a, a} << s; r[31:0] = d[63:32]; end
            4'd11: begin d = {a, a} >> s; r[31:0] = d[31:0]; end
            4'd12: begin r[31:0] = a + 32'd1; c = (a == 32'hFFFF_FFFF); end
            4'd13: begin r[31:0] = a - 32'd1; c = (a == 32'd0); end
            4'd14: begin r = {32'd0, a} * {32'd0, b}; c = (r[63:32] != 32'd0); end
            default: begin
                if (b == 32'd0) begin r = {a, 32'hFFFF_FFFF}; c = 1'b1; end
                else            r = {a % b, a / b};
            end
        endcase
        return {c, r};
    endfunction

    // Transaction-level model: accept when idle, finish after the op latency
    logic        m_busy = 1'b0, m_done = 1'b0, m_c = 1'b0, m_z = 1'b0, p_c = 1'b0;
    logic [63:0] m_res = '0, p_res = '0;
    int          m_left = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_res <= '0; m_c <= 1'b0; m_z <= 1'b0;
            m_left <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                if (m_left == 1) begin
                    m_busy <= 1'b0; m_done <= 1'b1;
                    m_res  <= p_res; m_c <= p_c; m_z <= (p_res == 64'd0);
                end
                m_left <= m_left - 1;
            end else if (bus.start) begin
                {p_c, p_res} <= model(bus.Opcode, bus.Operand1, bus.Operand2);
                m_busy <= 1'b1;
                m_left <= (bus.Opcode == 4'd14 || (bus.Opcode == 4'd15 && bus.Operand2 != 0))
                          ? W : 1;
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("busy",   64'(bus.busy),  64'(m_busy));
            chk("done",   64'(bus.done),  64'(m_done));
            chk("result", bus.Result,     m_res);
            chk("flagC",  64'(bus.flagC), 64'(m_c));
            chk("flagZ",  64'(bus.flagZ), 64'(m_z));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (called at a falling edge, return at a falling edge)
    // ------------------------------------------------------------------
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1; bus.Opcode = op; bus.Operand1 = a; bus.Operand2 = b;
        @(negedge clk);
        bus.start = 1'b0;
        acc_cyc   = cyc;
    endtask

    task automatic wait_done(input int max_cyc);
        int n = 0;
        while (bus.done !== 1'b1 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        if (bus.done !== 1'b1) begin
            checks++; failures++;
            $display("FAIL done_timeout waited=%0d limit=%0d", n, max_cyc);
        end
    endtask

    task automatic run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        issue(op, a, b);
        wait_done(40);
    endtask

    task automatic pin(input string name, input logic [63:0] res, input logic c,
                       input logic z, input int lat);
        chk({name, "_res"},   bus.Result,        res);
        chk({name, "_model"}, m_res,             res);
        chk({name, "_C"},     64'(bus.flagC),    64'(c));
        chk({name, "_Z"},     64'(bus.flagZ),    64'(z));
        chk({name, "_lat"},   64'(cyc - acc_cyc), 64'(lat));
    endtask

    initial begin
        rst = 1'b1; bus.start = 1'b0; bus.Opcode = '0; bus.Operand1 = '0; bus.Operand2 = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy",   64'(bus.busy),  64'd0);
        chk("rst_done",   64'(bus.done),  64'd0);
        chk("rst_result", bus.Result,     64'd0);
        chk("rst_flagC",  64'(bus.flagC), 64'd0);
        chk("rst_flagZ",  64'(bus.flagZ), 64'd0);
        check_en = 1'b1;
        rst = 1'b0;
        @(negedge clk);

        // Pinned vectors
        run(4'd0, 32'hABCD_ABCD, 32'h8363_5273); pin("add", 64'h0000_0000_2F30_FE40, 1, 0, 1);
        run(4'd1, 32'hABCD_ABCD, 32'h8363_5273); pin("sub", 64'h0000_0000_286A_595A, 0, 0, 1);
        run(4'd1, 32'h5, 32'h5);                 pin("sub_eq", 64'd0, 0, 1, 1);
        run(4'd8, 32'h8000_0001, 32'd1);         pin("shl", 64'h2, 1, 0, 1);
        run(4'd11, 32'h1, 32'd1);                pin("ror", 64'h8000_0000, 0, 0, 1);
        run(4'd15, 32'd100, 32'd7);              pin("div", {32'h2, 32'hE}, 0, 0, 32);
        run(4'd15, 32'h1234, 32'd0);             pin("div0", {32'h1234, 32'hFFFF_FFFF}, 1, 0, 1);
        run(4'd14, 32'hFFFF_FFFF, 32'hFFFF_FFFF); pin("mul_max", 64'hFFFF_FFFE_0000_0001, 1, 0, 32);

        // MUL with a start pulse mid-operation that must be ignored
        issue(4'd14, 32'd5, 32'd7);
        repeat (5) @(negedge clk);
        bus.start = 1'b1; bus.Opcode = 4'd0; bus.Operand1 = 32'd1; bus.Operand2 = 32'd2;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(40);
        pin("mul", 64'h23, 0, 0, 32);

        // Model-checked sweep, back to back
        run(4'd2, 32'hF0F0_1234, 32'h0FF0_FF00);
        run(4'd3, 32'hF0F0_1234, 32'h0FF0_FF00);
        run(4'd4, 32'hF0F0_1234, 32'h0FF0_FF00);
        run(4'd5, 32'hF0F0_1234, 32'h0FF0_FF00);
        run(4'd6, 32'hF0F0_1234, 32'h0FF0_FF00);
        run(4'd7, 32'hFFFF_FFFF, 32'h0);
        run(4'd8, 32'hDEAD_BEEF, 32'h20);        // s=0 via masked amount
        run(4'd8, 32'h3, 32'd31);
        run(4'd9, 32'h8000_0001, 32'd0);
        run(4'd9, 32'h8000_0001, 32'd1);
        run(4'd9, 32'h8000_0000, 32'd31);
        run(4'd10, 32'h8000_0001, 32'd4);
        run(4'd10, 32'h1234_5678, 32'd0);
        run(4'd11, 32'h1234_5678, 32'd12);
        run(4'd12, 32'hFFFF_FFFF, 32'd0);
        run(4'd12, 32'h7, 32'd0);
        run(4'd13, 32'h0, 32'd0);
        run(4'd13, 32'h10, 32'd0);
        run(4'd0, 32'hFFFF_FFFF, 32'h1);
        run(4'd1, 32'h1, 32'h2);
        run(4'd14, 32'h1234_5678, 32'h9ABC_DEF0);
        run(4'd14, 32'h0, 32'h1234);
        run(4'd15, 32'hFFFF_FFFF, 32'd1);
        run(4'd15, 32'd3, 32'd10);
        run(4'd15, 32'hDEAD_BEEF, 32'h0001_0003);

        // Reset aborts a running multiply
        issue(4'd14, 32'hFFFF, 32'h1234);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy",   64'(bus.busy), 64'd0);
        chk("abort_done",   64'(bus.done), 64'd0);
        chk("abort_result", bus.Result,    64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run(4'd0, 32'd3, 32'd4);
        pin("post_rst_add", 64'd7, 0, 0, 1);
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
